// File: rtl/mix_columns_seq_pkg.sv
// Shared definitions for the sequential AES MixColumns block.
//   GfPoly  : low byte of the AES reduction polynomial 0x11B
//   StateW  : width of an AES state
//   state_e : FSM state encoding
package mix_columns_seq_pkg;

  localparam logic [7:0]  GfPoly = 8'h1B;
  localparam int unsigned StateW = 128;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mix_columns_seq_gf_xtime.sv
// GF(2^8) multiply-by-two (xtime) with AES reduction.
//   a_i : input byte
//   y_o : 2 * a_i mod 0x11B
module gf_xtime
  import mix_columns_seq_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? GfPoly : 8'h00);

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES forward MixColumns: one column per cycle over four cycles.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake, state_in captured on accept
//   state_in             : AES state, byte k = state_in[127-8k -: 8]
//   out_valid / out_ready: output handshake, result held until taken
//   state_out            : MixColumns result, same byte order
module mix_columns_seq
  import mix_columns_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [StateW-1:0] state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [StateW-1:0] state_out
);

  state_e            st_q, st_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [StateW-1:0] state_q, state_d;

  logic [31:0] col;
  logic [31:0] col_new;
  logic [7:0]  a  [4];
  logic [7:0]  x2 [4];
  logic [7:0]  x3 [4];

  // Single column datapath, column chosen by the counter.
  always_comb begin
    col = 32'h0;
    case (cnt_q)
      2'd0:    col = state_q[127:96];
      2'd1:    col = state_q[95:64];
      2'd2:    col = state_q[63:32];
      default: col = state_q[31:0];
    endcase
  end

  assign a[0] = col[31:24];
  assign a[1] = col[23:16];
  assign a[2] = col[15:8];
  assign a[3] = col[7:0];

  for (genvar i = 0; i < 4; i++) begin : g_xtime
    gf_xtime u_xtime (
      .a_i(a[i]),
      .y_o(x2[i])
    );
    assign x3[i] = x2[i] ^ a[i];
  end

  assign col_new = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                    x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (st_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = state_in;
          cnt_d   = 2'd0;
          st_d    = StBusy;
        end
      end
      StBusy: begin
        case (cnt_q)
          2'd0:    state_d[127:96] = col_new;
          2'd1:    state_d[95:64]  = col_new;
          2'd2:    state_d[63:32]  = col_new;
          default: state_d[31:0]   = col_new;
        endcase
        // Counter wraps to 0 on the last column.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          st_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= 2'd0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with a software MixColumns model and an
// expected-result queue.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          cyc = 0;

  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state_in (state_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out)
  );

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
      r[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Accept one vector, wait (bounded) for out_valid, check latency and result.
  task automatic send_wait(input string tag, input logic [127:0] vec);
    int n;
    chk({tag, "_rdy"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    state_in = vec;
    exp_q.push_back(mix(vec));
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd4);
    chk({tag, "_res"}, state_out, pop_exp());
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("take_rdy", 128'(in_ready), 128'd1);
    chk("take_vld", 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] exp_r;
    logic [127:0] rv [8];
    int idx, outs, last_acc, guard;
    logic acc, hs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_rdy", 128'(in_ready), 128'd1);
    chk("rst_vld", 128'(out_valid), 128'd0);
    chk("rst_out", state_out, 128'h0);

    // Single column.
    send_wait("col1", 128'hdb135345_00000000_00000000_00000000);
    chk("col1_const", state_out, 128'h8e4da1bc_00000000_00000000_00000000);
    take();

    // FIPS-197 round 1, out_ready high while idle/busy has no effect.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_wait("fips", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    chk("fips_const", state_out, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    take();

    send_wait("ident", 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c);
    chk("ident_const", state_out, 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8);
    take();

    // Backpressure with in_valid held and state_in churning during BUSY.
    in_valid = 1'b1;
    state_in = 128'h00112233_44556677_8899aabb_ccddeeff;
    exp_r = mix(state_in);
    step();
    for (int i = 0; i < 4; i++) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      chk("bp_busy_rdy", 128'(in_ready), 128'd0);
      step();
    end
    chk("bp_vld", 128'(out_valid), 128'd1);
    chk("bp_res", state_out, exp_r);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_vld", 128'(out_valid), 128'd1);
      chk("bp_hold_rdy", 128'(in_ready), 128'd0);
      chk("bp_hold_out", state_out, exp_r);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_idle_rdy", 128'(in_ready), 128'd1);
    chk("bp_no_cap", state_out, exp_r);

    // Reset at the second BUSY edge.
    in_valid = 1'b1;
    state_in = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rdy", 128'(in_ready), 128'd1);
    chk("mrst_vld", 128'(out_valid), 128'd0);
    chk("mrst_out", state_out, 128'h0);
    step();
    chk("mrst_stay_vld", 128'(out_valid), 128'd0);
    send_wait("post_rst", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    chk("post_rst_const", state_out, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    take();

    // Back-to-back random states, both handshakes held high.
    for (int i = 0; i < 8; i++) rv[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; outs = 0; last_acc = -1; guard = 0;
    state_in = rv[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (outs < 8 && guard < 200) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        chk("b2b_res", state_out, pop_exp());
        outs++;
      end
      if (acc) begin
        exp_q.push_back(mix(state_in));
        if (last_acc >= 0) chk("b2b_gap", 128'(cyc - last_acc), 128'd6);
        last_acc = cyc;
        idx++;
      end
      step();
      if (acc) begin
        if (idx < 8) state_in = rv[idx];
        else in_valid = 1'b0;
      end
      guard++;
    end
    chk("b2b_count", 128'(outs), 128'd8);
    chk("b2b_q_empty", 128'(exp_q.size()), 128'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
